// File: rtl/rll_key_unlock_pipe.sv
// -----------------------------------------------------------------------------
// rll_key_unlock_pipe
//
// Sequential random-logic-locking key unlock block. A key is shifted in
// serially (LSB first, followed by one even-parity bit), checked, and committed
// to an internal key register. The committed key drives XOR/XNOR key gates on
// the first stage of a free-running data pipeline.
//
// Ports
//   clk            : rising-edge clock
//   rst            : asynchronous active-high reset
//   key_start      : begin / restart a serial key load
//   key_valid      : key_sin carries a bit this cycle
//   key_sin        : serial key bit (KEY_W data bits LSB first, then parity)
//   key_done       : one-cycle pulse while a good load is being committed
//   key_err        : one-cycle pulse when a load fails its parity check
//   locked         : high until the first successful commit after reset
//   data_in        : data to pass through the key gates
//   data_in_valid  : data_in qualifier
//   data_out       : keyed data, PIPE cycles after capture
//   data_out_valid : data_out qualifier
//
// Parameter constraints: 1 <= KEY_W <= DATA_W, PIPE >= 1.
// -----------------------------------------------------------------------------
module rll_key_unlock_pipe #(
  parameter int              DATA_W  = 16,
  parameter int              KEY_W   = 8,
  parameter logic [KEY_W-1:0] KEY_POL = 8'hA5,
  parameter int              PIPE    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_start,
  input  logic              key_valid,
  input  logic              key_sin,
  output logic              key_done,
  output logic              key_err,
  output logic              locked,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // ---------------------------------------------------------------------------
  // Key load control state
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_q,    key_d;
  logic             key_done_q, key_done_d;
  logic             key_err_q,  key_err_d;
  logic             locked_q,   locked_d;

  // Parity verdict is taken on the parity-bit edge and registered into
  // key_done_q / key_err_q, so both pulses come straight from flops during
  // CHECK. CHECK then commits based on key_done_q alone.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    key_d      = key_q;
    locked_d   = locked_q;
    key_done_d = 1'b0;
    key_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_start) begin
          state_d  = ST_SHIFT;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end

      ST_SHIFT: begin
        if (key_start) begin
          // Restart: drop the partial key; a simultaneous key_valid is ignored.
          cnt_d    = '0;
          shadow_d = '0;
        end else if (key_valid) begin
          if (cnt_q == CNT_W'(KEY_W)) begin
            state_d    = ST_CHECK;
            key_done_d = ((^shadow_q) == key_sin);
            key_err_d  = ((^shadow_q) != key_sin);
          end else begin
            for (int i = 0; i < KEY_W; i++) begin
              if (cnt_q == CNT_W'(i)) begin
                shadow_d[i] = key_sin;
              end
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_CHECK: begin
        // key_start is deliberately not looked at here.
        if (key_done_q) begin
          key_d    = shadow_q;
          locked_d = 1'b0;
        end
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      key_q      <= '0;
      key_done_q <= 1'b0;
      key_err_q  <= 1'b0;
      locked_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      key_q      <= key_d;
      key_done_q <= key_done_d;
      key_err_q  <= key_err_d;
      locked_q   <= locked_d;
    end
  end

  assign key_done = key_done_q;
  assign key_err  = key_err_q;
  assign locked   = locked_q;

  // ---------------------------------------------------------------------------
  // Stage 1: key gates
  // ---------------------------------------------------------------------------
  // Each gate flips its data bit when the key bit differs from the gate's
  // polarity, so the path is transparent exactly when key == KEY_POL.
  // key_d is used so that data captured on the commit edge already sees the
  // new key, while data already past stage 1 keeps the old one.
  logic [DATA_W-1:0] gate_mask;

  always_comb begin
    gate_mask              = '0;
    gate_mask[KEY_W-1:0]   = key_d ^ KEY_POL;
  end

  // ---------------------------------------------------------------------------
  // Stages 2..PIPE: plain delay registers, holding data while invalid
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] pipe_data_q [PIPE];
  logic [DATA_W-1:0] pipe_data_d [PIPE];
  logic [PIPE-1:0]   pipe_vld_q;
  logic [PIPE-1:0]   pipe_vld_d;

  always_comb begin
    pipe_vld_d[0]  = data_in_valid;
    pipe_data_d[0] = data_in_valid ? (data_in ^ gate_mask) : pipe_data_q[0];
    for (int k = 1; k < PIPE; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_data_d[k] = pipe_vld_q[k-1] ? pipe_data_q[k-1] : pipe_data_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < PIPE; k++) begin
        pipe_data_q[k] <= '0;
      end
    end else begin
      pipe_vld_q <= pipe_vld_d;
      for (int k = 0; k < PIPE; k++) begin
        pipe_data_q[k] <= pipe_data_d[k];
      end
    end
  end

  assign data_out       = pipe_data_q[PIPE-1];
  assign data_out_valid = pipe_vld_q[PIPE-1];

endmodule

// File: tb/tb_rll_key_unlock_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for rll_key_unlock_pipe: randomized stimulus, a queue-based
// reference model of key loading and keyed data, and a negedge monitor that
// compares DUT outputs against the model.
// -----------------------------------------------------------------------------
module tb_rll_key_unlock_pipe;

  localparam int         DATA_W  = 16;
  localparam int         KEY_W   = 8;
  localparam logic [7:0] KEY_POL = 8'hA5;
  localparam int         PIPE    = 2;

  logic              clk;
  logic              rst;
  logic              key_start;
  logic              key_valid;
  logic              key_sin;
  logic              key_done;
  logic              key_err;
  logic              locked;
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;

  rll_key_unlock_pipe #(
    .DATA_W (DATA_W),
    .KEY_W  (KEY_W),
    .KEY_POL(KEY_POL),
    .PIPE   (PIPE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_start     (key_start),
    .key_valid     (key_valid),
    .key_sin       (key_sin),
    .key_done      (key_done),
    .key_err       (key_err),
    .locked        (locked),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_out      (data_out),
    .data_out_valid(data_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int unsigned       due;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;

  logic [7:0] key_m      = 8'h00;
  bit         locked_m   = 1'b1;
  bit         loading_m  = 1'b0;
  bit         chk_pend_m = 1'b0;
  bit         chk_ok_m   = 1'b0;
  logic [7:0] ld_key_m   = 8'h00;
  bit         bits_m[$];
  bit         exp_done   = 1'b0;
  bit         exp_err    = 1'b0;

  // A key gate is transparent for the matching key bit and inverts otherwise.
  function automatic logic [DATA_W-1:0] keyed(input logic [DATA_W-1:0] d, input logic [7:0] k);
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < KEY_W; i++) begin
      if (k[i] != KEY_POL[i]) r[i] = ~r[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    key_m      = 8'h00;
    locked_m   = 1'b1;
    loading_m  = 1'b0;
    chk_pend_m = 1'b0;
    chk_ok_m   = 1'b0;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    bits_m.delete();
    exp_q.delete();
  endtask

  always @(posedge clk) begin
    int ones;
    cyc++;
    if (!rst) begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (chk_pend_m) begin
        if (chk_ok_m) begin
          key_m    = ld_key_m;
          locked_m = 1'b0;
        end
        chk_pend_m = 1'b0;
      end else if (key_start) begin
        loading_m = 1'b1;
        bits_m.delete();
      end else if (loading_m && key_valid) begin
        bits_m.push_back(key_sin);
        if (bits_m.size() == KEY_W + 1) begin
          ones = 0;
          for (int i = 0; i < KEY_W; i++) begin
            ld_key_m[i] = bits_m[i];
            ones += int'(bits_m[i]);
          end
          chk_ok_m   = ((ones % 2) == int'(bits_m[KEY_W]));
          exp_done   = chk_ok_m;
          exp_err    = !chk_ok_m;
          chk_pend_m = 1'b1;
          loading_m  = 1'b0;
        end
      end
      if (data_in_valid) begin
        exp_q.push_back('{due: cyc + PIPE - 1, val: keyed(data_in, key_m)});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] last_out = '0;
  int                done_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    chk("key_done", key_done, exp_done);
    chk("key_err",  key_err,  exp_err);
    chk("locked",   locked,   locked_m);
    if (key_done) done_cnt++;
    if (data_out_valid) begin
      last_out = data_out;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL data_unexpected: got %0h with nothing expected", data_out);
      end else begin
        e = exp_q.pop_front();
        chk("data_latency", cyc, e.due);
        chk("data_out", data_out, e.val);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL data_missing: got no valid expected %0h", exp_q[0].val);
      void'(exp_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc_drive(input bit st, input bit v, input bit s);
    key_start     = st;
    key_valid     = v;
    key_sin       = s;
    data_in       = DATA_W'($urandom);
    data_in_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      key_start     = 1'b0;
      key_valid     = 1'b0;
      key_sin       = 1'b0;
      data_in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_data(input logic [DATA_W-1:0] d);
    key_start     = 1'b0;
    key_valid     = 1'b0;
    key_sin       = 1'b0;
    data_in       = d;
    data_in_valid = 1'b1;
    @(negedge clk);
    idle(PIPE + 1);
  endtask

  task automatic load_key(input logic [7:0] k, input bit par, input int gap, input bit start_valid);
    cyc_drive(1'b1, start_valid, 1'b1);
    for (int i = 0; i <= KEY_W; i++) begin
      repeat (gap) cyc_drive(1'b0, 1'b0, 1'($urandom));
      cyc_drive(1'b0, 1'b1, (i < KEY_W) ? k[i] : par);
    end
    cyc_drive(1'b0, 1'b0, 1'b0);
    cyc_drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_key_done", key_done, 1'b0);
    chk("rst_key_err", key_err, 1'b0);
    chk("rst_locked", locked, 1'b1);
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_data_out_valid", data_out_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst           = 1'b1;
    key_start     = 1'b0;
    key_valid     = 1'b0;
    key_sin       = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    chk("init_locked", locked, 1'b1);
    chk("init_data_out_valid", data_out_valid, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);

    // Locked path: wrong key (all zeros) scrambles the low byte.
    send_data(16'h1234);
    chk("locked_1234", last_out, 16'h1291);
    repeat (20) cyc_drive(1'b0, 1'b0, 1'b0);

    // Correct key A5 with good parity.
    load_key(8'hA5, 1'b0, 0, 1'b0);
    chk("unlock_locked", locked, 1'b0);
    send_data(16'h1234);
    chk("unlocked_1234", last_out, 16'h1234);

    // Key FF commits; data in flight at the commit edge keeps A5.
    load_key(8'hFF, 1'b0, 1, 1'b0);
    send_data(16'h0000);
    chk("key_ff_0000", last_out, 16'h005A);

    // Restart after 4 bits (restart cycle also carries key_valid), 3-cycle gaps.
    d0 = done_cnt;
    cyc_drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc_drive(1'b0, 1'b1, 1'($urandom));
    load_key(8'hA5, 1'b0, 3, 1'b1);
    chk("restart_single_done", done_cnt - d0, 1);
    send_data(16'h1234);
    chk("restart_key_a5", last_out, 16'h1234);

    // Bad parity: rejected, key unchanged (still A5), no relock.
    d0 = done_cnt;
    load_key(8'h3C, 1'b1, 0, 1'b0);
    chk("bad_parity_no_done", done_cnt - d0, 0);
    chk("bad_parity_still_unlocked", locked, 1'b0);
    send_data(16'h1234);
    chk("bad_parity_key_kept", last_out, 16'h1234);

    // Async reset in the middle of a load.
    cyc_drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc_drive(1'b0, 1'b1, 1'($urandom));
    async_reset();
    send_data(16'h1234);
    chk("post_rst_1234", last_out, 16'h1291);

    // Fresh reset: A5 with bad parity is rejected and the block stays locked.
    load_key(8'hA5, 1'b1, 0, 1'b0);
    chk("bad_parity_locked", locked, 1'b1);
    send_data(16'h1234);
    chk("bad_parity_1234", last_out, 16'h1291);

    // Random loads with arbitrary keys and parity.
    for (int n = 0; n < 8; n++) begin
      load_key(8'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    end

    // Fully random control and data traffic.
    for (int n = 0; n < 500; n++) begin
      cyc_drive(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom));
    end

    idle(PIPE + 3);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
